hs_width_packer: RTL and testbench

- Handshake width upsizer. Consumes narrow beats from an upstream valid/ready handshake channel and packs RATIO consecutive beats into one wide word.
- Presents the wide word on a downstream valid/ready channel.
- Sits directly downstream of a handshake master, typically a byte stream feeding a word-wide datapath.
- Sustains one input beat per cycle when downstream is ready.

---
 rtl/hs_width_packer_pkg.sv | 24 ++
 rtl/hs_width_packer.sv | 114 +++++++++++
 tb/tb_hs_width_packer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hs_width_packer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : hs_pkg                                                          |
// | Purpose  : Shared types, limits and helpers for the hs_width_packer block. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package hs_pkg;

  localparam int HS_MAX_RATIO = 16;

  // Packing phase decoded from the beat counter.
  typedef enum logic {
    PH_FILL = 1'b0,
    PH_LAST = 1'b1
  } hs_phase_e;

  function automatic int hs_cnt_width(input int ratio);
    int w;
    w = $clog2(ratio);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hs_width_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hs_width_packer                                                 |
// | Purpose  : Valid/ready width upsizer; packs RATIO narrow beats little-     |
// |            endian into one wide word. Define HS_WIDTH_PACKER_LAST_EN to    |
// |            add in_last/out_last/out_keep early word termination.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module hs_width_packer
  import hs_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4,
  parameter int OUT_WIDTH  = DATA_WIDTH * RATIO
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
`ifdef HS_WIDTH_PACKER_LAST_EN
  input  logic                  in_last,
  output logic                  out_last,
  output logic [RATIO-1:0]      out_keep,
`endif
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int                CNT_W    = hs_cnt_width(RATIO);
  localparam int                ACC_W    = (RATIO - 1) * DATA_WIDTH;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RATIO - 1);

  generate
    if ((RATIO < 2) || (RATIO > HS_MAX_RATIO)) begin : g_bad_ratio
      $error("hs_width_packer: RATIO must be in 2..%0d", HS_MAX_RATIO);
    end
    if (OUT_WIDTH != DATA_WIDTH * RATIO) begin : g_bad_out_width
      $error("hs_width_packer: OUT_WIDTH must equal DATA_WIDTH*RATIO");
    end
  endgenerate

  logic [CNT_W-1:0]     cnt;
  logic [ACC_W-1:0]     acc;
  hs_phase_e            phase;
  logic                 close_beat;
  logic                 in_fire;
  logic [OUT_WIDTH-1:0] word_next;

  assign phase = (cnt == CNT_LAST) ? PH_LAST : PH_FILL;

`ifdef HS_WIDTH_PACKER_LAST_EN
  logic [RATIO-1:0] keep_next;

  // An early-closing beat needs the output register just like a final beat,
  // so in_ready looks at in_last (beat sideband), never at in_valid.
  assign close_beat = (phase == PH_LAST) | in_last;

  always_comb begin
    word_next = '0;
    keep_next = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (k < int'(cnt))
        word_next[k*DATA_WIDTH +: DATA_WIDTH] = acc[k*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int k = 0; k < RATIO; k++) begin
      if (k == int'(cnt))
        word_next[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
      keep_next[k] = (k <= int'(cnt));
    end
  end
`else
  assign close_beat = (phase == PH_LAST);
  assign word_next  = {in_data, acc};
`endif

  // Partial beats always flow; only a word-closing beat waits for a free output.
  assign in_ready = rst & (~close_beat | ~out_valid | out_ready);
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
`ifdef HS_WIDTH_PACKER_LAST_EN
      out_keep  <= '0;
      out_last  <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (in_fire) begin
        if (close_beat) begin
          // acc keeps stale bits; the next word overwrites every slice it uses.
          out_data  <= word_next;
          out_valid <= 1'b1;
          cnt       <= '0;
`ifdef HS_WIDTH_PACKER_LAST_EN
          out_keep  <= keep_next;
          out_last  <= in_last;
`endif
        end else begin
          acc[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hs_width_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_hs_width_packer                                              |
// | Purpose  : Scoreboard bench for hs_width_packer (DATA_WIDTH=8, RATIO=4).   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_hs_width_packer;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int OW = DW * R;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
`ifdef HS_WIDTH_PACKER_LAST_EN
  logic          in_last;
  logic          out_last;
  logic [R-1:0]  out_keep;
`endif

  int            checks = 0;
  int            errors = 0;
  logic [OW-1:0] sb_q[$];
  logic [OW-1:0] m_acc = '0;
  int            m_cnt = 0;
  int            rst_count = 0;
  bit            expect_ready = 1'b0;

  hs_width_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef HS_WIDTH_PACKER_LAST_EN
    .in_last   (in_last),
    .out_last  (out_last),
    .out_keep  (out_keep),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output side: pops the scoreboard on every accepted word and checks hold stability.
  task automatic monitor();
    logic          stalled = 1'b0;
    logic [OW-1:0] held = '0;
    int            seen_rst = 0;
    logic [OW:0]   e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (stalled && seen_rst == rst_count) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_data", 64'(out_data), 64'(held));
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() > 0) e = {1'b0, sb_q.pop_front()};
          else                 e = {1'b1, {OW{1'b0}}};
          check("sb_word", 64'({1'b0, out_data}), 64'(e));
        end
        stalled = out_valid && !out_ready;
        held    = out_data;
      end else begin
        stalled = 1'b0;
      end
      seen_rst = rst_count;
    end
  endtask

  // Drives one beat until accepted; the model builds the expected word.
  task automatic send_beat(input logic [DW-1:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (i == 0 && expect_ready) check("no_bubble", 64'(in_ready), 64'd1);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 'x;
    if (!ok) begin
      check("in_timeout", 64'd0, 64'd1);
    end else begin
      m_acc[m_cnt*DW +: DW] = d;
      m_cnt++;
`ifdef HS_WIDTH_PACKER_LAST_EN
      if (m_cnt == R || in_last) begin
`else
      if (m_cnt == R) begin
`endif
        sb_q.push_back(m_acc);
        m_acc = '0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() > 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    bit done;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef HS_WIDTH_PACKER_LAST_EN
    in_last   = 1'b0;
`endif
    fork
      monitor();
    join_none

    // Reset and idle
    repeat (5) begin
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // Basic pack
    @(posedge clk); #1;
    out_ready    = 1'b1;
    expect_ready = 1'b1;
    send_beat(8'h11); send_beat(8'h22); send_beat(8'h33); send_beat(8'h44);
    check("basic_valid", 64'(out_valid), 64'd1);
    check("basic_data", 64'(out_data), 64'h4433_2211);
    @(posedge clk); #1;
    check("basic_valid_drop", 64'(out_valid), 64'd0);

    // Backpressure: full word held while partial beats keep flowing
    expect_ready = 1'b0;
    out_ready    = 1'b0;
    for (int b = 1; b <= 7; b++) send_beat(DW'(b));
    in_valid = 1'b1;
    in_data  = 8'h08;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_held_data", 64'(out_data), 64'h0403_0201);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send_beat(8'h08);
    check("bp_next_valid", 64'(out_valid), 64'd1);
    check("bp_next_data", 64'(out_data), 64'h0807_0605);

    // Continuous stream with random input gaps, downstream always ready
    expect_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send_beat(DW'($urandom));
    end
    expect_ready = 1'b0;

    // Random downstream backpressure
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send_beat(DW'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset mid-operation discards the pending word and the partial word
    out_ready = 1'b0;
    send_beat(8'hC0); send_beat(8'hC1); send_beat(8'hC2); send_beat(8'hC3);
    send_beat(8'hC4); send_beat(8'hC5);
    @(posedge clk); #2;
    rst = 1'b0;
    rst_count++;
    sb_q.delete();
    m_acc = '0;
    m_cnt = 0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_beat(8'hA0); send_beat(8'hA1); send_beat(8'hA2); send_beat(8'hA3);
    check("post_rst_data", 64'(out_data), 64'hA3A2_A1A0);
    check("post_rst_valid", 64'(out_valid), 64'd1);

`ifdef HS_WIDTH_PACKER_LAST_EN
    // Early close via in_last
    drain();
    send_beat(8'hAA);
    in_last = 1'b1;
    send_beat(8'hBB);
    in_last = 1'b0;
    check("last_data", 64'(out_data), 64'h0000_BBAA);
    check("last_keep", 64'(out_keep), 64'b0011);
    check("last_flag", 64'(out_last), 64'd1);
    for (int b = 0; b < R; b++) send_beat(DW'(8'h50 + b));
    check("full_keep", 64'(out_keep), 64'b1111);
    check("full_last", 64'(out_last), 64'd0);
`endif

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
